pipelined_4stage: RTL and testbench



---
 rtl/pipelined_4stage.sv | 202 ++++++++++++++++++++
 tb/tb_pipelined_4stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pipelined_4stage.sv
// ---------------------------------------------------------------------------
// pipelined_4stage
//   Self-contained 4-stage in-order 32-bit core: IF -> ID -> EX -> WB.
//   Program lives in an internal ROM and registers in an internal register file.
//   The only visible output is the EX/WB copy of the ALU result.
//
// Ports
//   clk     in   1   single clock, all state updates on its rising edge
//   rst     in   1   asynchronous, active-high reset (clears all state)
//   aluout  out  32  EX/WB result register (0 for NOP/HALT)
//
// Configuration macro
//   PIPE_FORWARD_EN  when defined, EX operands take the EX/WB result if the
//                    source register matches the EX/WB destination (wen=1).
//                    When undefined, operands come only from the ID read, so a
//                    distance-1 dependency sees the stale register value.
// ---------------------------------------------------------------------------
module pipelined_4stage #(
    parameter int ROM_DEPTH = 32,
    parameter int NREGS     = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] aluout
);

    localparam int PCW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LUI  = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SLT  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Program image; encoding {op, rd, rs, rt, imm16}.
    function automatic logic [31:0] rom_word(input logic [PCW-1:0] addr);
        logic [31:0] w;
        w = 32'h0;
        case (int'(addr))
            0:  w = 32'h6100_0005; // ADDI r1,r0,5
            1:  w = 32'h6200_0003; // ADDI r2,r0,3
            2:  w = 32'h1312_0000; // ADD  r3,r1,r2
            3:  w = 32'h2432_0000; // SUB  r4,r3,r2
            4:  w = 32'h3534_0000; // AND  r5,r3,r4
            5:  w = 32'h4634_0000; // OR   r6,r3,r4
            6:  w = 32'h5761_0000; // XOR  r7,r6,r1
            7:  w = 32'h8812_0000; // SLL  r8,r1,r2
            8:  w = 32'hA921_0000; // SLT  r9,r2,r1
            9:  w = 32'h7A00_1234; // LUI  r10,0x1234
            10: w = 32'h6000_0007; // ADDI r0,r0,7
            11: w = 32'h1B01_0000; // ADD  r11,r0,r1
            12: w = 32'hF000_0000; // HALT
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // ---------------- state ----------------
    logic [PCW-1:0] pc_reg;
    logic [31:0]    if_id_reg;
    logic [3:0]     id_ex_op_reg;
    logic [3:0]     id_ex_rd_reg;
    logic [31:0]    id_ex_a_reg;
    logic [31:0]    id_ex_b_reg;
    logic [15:0]    id_ex_imm_reg;
`ifdef PIPE_FORWARD_EN
    logic [3:0]     id_ex_rs_reg;
    logic [3:0]     id_ex_rt_reg;
`endif
    logic [31:0]    ex_wb_result_reg;
    logic [3:0]     ex_wb_rd_reg;
    logic           ex_wb_wen_reg;
    logic [31:0]    regs [NREGS];

    // ---------------- IF ----------------
    logic [31:0]    fetch_word;
    logic [PCW-1:0] pc_next;

    always_comb begin
        fetch_word = rom_word(pc_reg);
        pc_next    = pc_reg;
        // HALT freezes the PC so the same HALT word is refetched forever.
        if (fetch_word[31:28] != OP_HALT) begin
            if (pc_reg == PCW'(ROM_DEPTH - 1))
                pc_next = '0;
            else
                pc_next = pc_reg + 1'b1;
        end
    end

    // ---------------- ID ----------------
    logic [3:0]  id_op, id_rd, id_rs, id_rt;
    logic [31:0] id_a, id_b;

    always_comb begin
        id_op = if_id_reg[31:28];
        id_rd = if_id_reg[27:24];
        id_rs = if_id_reg[23:20];
        id_rt = if_id_reg[19:16];
        // Write-through: the value being written back this cycle bypasses the array.
        if (id_rs == 4'd0)
            id_a = 32'h0;
        else if (ex_wb_wen_reg && (ex_wb_rd_reg == id_rs))
            id_a = ex_wb_result_reg;
        else
            id_a = regs[id_rs];
        if (id_rt == 4'd0)
            id_b = 32'h0;
        else if (ex_wb_wen_reg && (ex_wb_rd_reg == id_rt))
            id_b = ex_wb_result_reg;
        else
            id_b = regs[id_rt];
    end

    // ---------------- EX ----------------
    logic [31:0] ex_a, ex_b, ex_result;
    logic        ex_wen;

    always_comb begin
`ifdef PIPE_FORWARD_EN
        // The instruction just ahead is in EX/WB; its rd is never 0 when wen=1.
        ex_a = (ex_wb_wen_reg && (ex_wb_rd_reg == id_ex_rs_reg)) ? ex_wb_result_reg : id_ex_a_reg;
        ex_b = (ex_wb_wen_reg && (ex_wb_rd_reg == id_ex_rt_reg)) ? ex_wb_result_reg : id_ex_b_reg;
`else
        ex_a = id_ex_a_reg;
        ex_b = id_ex_b_reg;
`endif
        ex_result = 32'h0;
        ex_wen    = 1'b0;
        case (id_ex_op_reg)
            OP_ADD:  ex_result = ex_a + ex_b;
            OP_SUB:  ex_result = ex_a - ex_b;
            OP_AND:  ex_result = ex_a & ex_b;
            OP_OR:   ex_result = ex_a | ex_b;
            OP_XOR:  ex_result = ex_a ^ ex_b;
            OP_ADDI: ex_result = ex_a + {{16{id_ex_imm_reg[15]}}, id_ex_imm_reg};
            OP_LUI:  ex_result = {id_ex_imm_reg, 16'h0};
            OP_SLL:  ex_result = ex_a << ex_b[4:0];
            OP_SRL:  ex_result = ex_a >> ex_b[4:0];
            OP_SLT:  ex_result = ($signed(ex_a) < $signed(ex_b)) ? 32'd1 : 32'd0;
            default: ex_result = 32'h0; // NOP, HALT, unused B-E
        endcase
        if ((id_ex_op_reg >= OP_ADD) && (id_ex_op_reg <= OP_SLT) && (id_ex_rd_reg != 4'd0))
            ex_wen = 1'b1;
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg           <= '0;
            if_id_reg        <= 32'h0;
            id_ex_op_reg     <= OP_NOP;
            id_ex_rd_reg     <= 4'd0;
            id_ex_a_reg      <= 32'h0;
            id_ex_b_reg      <= 32'h0;
            id_ex_imm_reg    <= 16'h0;
`ifdef PIPE_FORWARD_EN
            id_ex_rs_reg     <= 4'd0;
            id_ex_rt_reg     <= 4'd0;
`endif
            ex_wb_result_reg <= 32'h0;
            ex_wb_rd_reg     <= 4'd0;
            ex_wb_wen_reg    <= 1'b0;
        end else begin
            pc_reg           <= pc_next;
            if_id_reg        <= fetch_word;
            id_ex_op_reg     <= id_op;
            id_ex_rd_reg     <= id_rd;
            id_ex_a_reg      <= id_a;
            id_ex_b_reg      <= id_b;
            id_ex_imm_reg    <= if_id_reg[15:0];
`ifdef PIPE_FORWARD_EN
            id_ex_rs_reg     <= id_rs;
            id_ex_rt_reg     <= id_rt;
`endif
            ex_wb_result_reg <= ex_result;
            ex_wb_rd_reg     <= id_ex_rd_reg;
            ex_wb_wen_reg    <= ex_wen;
        end
    end

    // ---------------- WB / register file ----------------
    // Reset clears every register, so the array cannot map to block RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= 32'h0;
        end else if (ex_wb_wen_reg && (ex_wb_rd_reg != 4'd0)) begin
            regs[ex_wb_rd_reg] <= ex_wb_result_reg;
        end
    end

    assign aluout = ex_wb_result_reg;

endmodule

// File: tb/tb_pipelined_4stage.sv
// ---------------------------------------------------------------------------
// tb_pipelined_4stage
//   Scoreboard bench for pipelined_4stage. The expected aluout trace for the
//   built-in program is queued when reset is released, then popped and compared
//   one entry per rising edge (sampled 1 ns after the edge).
//   Also covers async mid-run reset and HALT behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipelined_4stage;

    logic        clk;
    logic        rst;
    logic [31:0] aluout;

    pipelined_4stage dut (
        .clk    (clk),
        .rst    (rst),
        .aluout (aluout)
    );

    // Period 20 ns; first rising edge at 20 ns so a 0..10 ns reset pulse ends
    // on a falling edge.
    initial clk = 1'b1;
    always #10 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
        end else begin
            $display("ok   %s: %08h", tag, act);
        end
    endtask

    // Hand-derived trace of the built-in program, addresses 0..12.
    // Without forwarding, a distance-1 source reads its stale value.
    function automatic logic [31:0] prog_result(input int addr);
        logic [31:0] r;
        case (addr)
            0:  r = 32'd5;
            1:  r = 32'd3;
`ifdef PIPE_FORWARD_EN
            2:  r = 32'd8;
            3:  r = 32'd5;
            4:  r = 32'd0;
            5:  r = 32'd13;
            6:  r = 32'd8;
`else
            2:  r = 32'd5;          // r2 stale 0
            3:  r = 32'hFFFF_FFFD;  // r3 stale 0, r2=3
            4:  r = 32'd0;          // r3=5, r4 stale 0
            5:  r = 32'hFFFF_FFFD;  // 5 | FFFFFFFD
            6:  r = 32'd5;          // r6 stale 0 ^ r1
`endif
            7:  r = 32'd40;
            8:  r = 32'd1;
            9:  r = 32'h1234_0000;
            10: r = 32'd7;
            11: r = 32'd5;
            default: r = 32'd0;     // HALT and beyond
        endcase
        return r;
    endfunction

    // Queue the expected values for `n` edges after a reset release: two
    // bubble edges, then one instruction result per edge.
    task automatic push_trace(input int n);
        for (int e = 1; e <= n; e++) begin
            if (e < 3) sb.push_back(32'h0);
            else       sb.push_back(prog_result(e - 3));
        end
    endtask

    task automatic run_edges(input int n, input string phase);
        logic [31:0] exp;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check_eq({phase, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                exp = sb.pop_front();
                check_eq($sformatf("%s_edge%0d", phase, e), aluout, exp);
            end
        end
    endtask

    initial begin
        // ---- power-on reset: 10 ns pulse ----
        rst = 1'b1;
        #5;
        check_eq("reset_during_aluout", aluout, 32'h0);
        #5;
        rst = 1'b0;
        #1;
        check_eq("reset_after_aluout", aluout, 32'h0);
        check_eq("reset_after_pc", 32'(dut.pc_reg), 32'h0);

        // ---- full program trace plus halt tail (40 edges = 800 ns) ----
        push_trace(40);
        run_edges(40, "run");
        check_eq("halt_r11", dut.regs[11], 32'd5);
        check_eq("halt_r0", dut.regs[0], 32'd0);
        check_eq("halt_pc", 32'(dut.pc_reg), 32'd12);

        // ---- fresh run, then async reset while aluout shows addr2 ----
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_trace(5);
        run_edges(5, "pre_mid");
        #5;
        rst = 1'b1;
        #1;
        check_eq("mid_reset_aluout", aluout, 32'h0);
        check_eq("mid_reset_pc", 32'(dut.pc_reg), 32'h0);
        check_eq("mid_reset_r1", dut.regs[1], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        push_trace(6);
        run_edges(6, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
